lfsr_axi_master: RTL and testbench
==================================

LFSR_AXI_MASTER -- requirements
Module: lfsr_axi_master

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 4, AXI-Lite address width; DATA_WIDTH, default 8, AXI-Lite data width.
REQ-002 SHALL have ports: clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have: resetn  input  1  synchronous, active-low reset.
REQ-004 SHALL have: start  input  1  one-cycle request to run a sequence; sampled only in IDLE.
REQ-005 SHALL have: cfg_seed  input  8  seed; cfg_taps  input  8  taps; cfg_count  input  8  number of LFSR samples to read.
REQ-006 SHALL have: busy  output  1  high from the start accept cycle until the done cycle inclusive.
REQ-007 SHALL have: done  output  1  one-cycle pulse at sequence end; error  output  1  valid with done.
REQ-008 SHALL have: sample_data  output  8  LFSR sample; sample_valid  output  1; sample_ready  input  1.
REQ-009 SHALL have AXI-Lite master ports: m_axi_awaddr/awvalid out, awready in; wdata/wvalid out, wready in; bresp in (2), bvalid in, bready out.
REQ-010 SHALL have: m_axi_araddr/arvalid out, arready in; rdata in (DATA_WIDTH), rvalid in, rready out.

Function
REQ-011 SHALL latch cfg_seed, cfg_taps and cfg_count on the cycle start is accepted in IDLE; later changes SHALL have no effect.
REQ-012 SHALL ignore start while busy.
REQ-013 SHALL issue writes in this order: addr 0x0 data 0x00; 0x4 seed; 0x8 taps; 0x0 0x02 (load); 0x0 0x01 (enable).
REQ-014 After the fifth write, SHALL issue cfg_count reads of addr 0xC, then a final write of 0x0 with data 0x00.
REQ-015 States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, SAMPLE, DONE.
REQ-016 WR_REQ: SHALL assert awvalid and wvalid in the same cycle, with address and data stable.
REQ-017 WR_REQ: SHALL drop each of awvalid and wvalid independently on its own handshake cycle.
REQ-018 SHALL leave WR_REQ only when both handshakes are complete, including the cycle where both complete together.
REQ-019 WR_RESP: SHALL hold bready high; on bvalid&bready, SHALL check bresp.
REQ-020 RD_REQ: SHALL assert arvalid with araddr=0xC until arvalid&arready.
REQ-021 RD_RESP: SHALL hold rready high and capture rdata into sample_data on rvalid&rready.
REQ-022 SAMPLE: SHALL hold sample_valid and sample_data until sample_ready; the next read SHALL not be issued before acceptance.
REQ-023 A sample SHALL be accepted in the cycle sample_valid and sample_ready are both high; the next state is RD_REQ if reads remain, else WR_REQ for the final write.
REQ-024 cfg_count=0 SHALL skip all reads and proceed directly to the final write.
REQ-025 A bresp other than 2'b00 on any write SHALL abort the sequence without further transactions.
REQ-026 On abort, the block SHALL enter DONE with error=1 (SLVERR=2'b10 and DECERR=2'b11 treated the same).
REQ-027 DONE: SHALL pulse done for one cycle, set error as decided, then return to IDLE; error SHALL be 0 whenever done is 0.
REQ-028 At most one AXI transaction SHALL be outstanding; no valid SHALL depend combinationally on a ready.
REQ-029 The internal read counter SHALL be 8 bits and count down from the latched count without wrap.

Reset
REQ-030 While resetn=0 at a rising edge, state SHALL go to IDLE.
REQ-031 While resetn=0 at a rising edge, all valid/ready outputs, busy, done, error and sample_valid SHALL go to 0.
REQ-032 While resetn=0 at a rising edge, awaddr/araddr/wdata/sample_data and the internal counter SHALL go to 0.
REQ-033 Reset mid-transaction SHALL abandon the transaction immediately; no done pulse SHALL follow.

Verification
REQ-034 Bench SHALL cover: reset held 3 cycles -> all outputs 0, state IDLE.
REQ-035 Bench SHALL cover: start, seed 0xA5, taps 0xB4, count 3, responder always ready, rdata 0x4B,0x97,0x2E -> exact write order per REQ-013/014, three samples out in order, done=1, error=0.
REQ-036 Bench SHALL cover: responder delays awready 2 cycles and wready 4 cycles -> awvalid drops alone first, no extra or duplicate write.
REQ-037 Bench SHALL cover: sample_ready low 5 cycles -> sample_valid and sample_data held, arvalid stays 0.
REQ-038 Bench SHALL cover: bresp=2'b10 on the taps write -> no load write issued, done with error=1.
REQ-039 Bench SHALL cover: count=0 -> five writes then final ctrl=0x00 write, no reads; start pulsed while busy is ignored.

Source files
------------

// File: rtl/lfsr_axi_master.sv
// Sequences an AXI-Lite LFSR peripheral: configure, read cfg_count samples, disable.
// Latency: 2+ cycles per write, 3+ cycles per read sample, plus one DONE cycle.
// Backpressure: one AXI transaction at a time; next read waits for sample_ready.
module lfsr_axi_master #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [7:0]            cfg_seed,
  input  logic [7:0]            cfg_taps,
  input  logic [7:0]            cfg_count,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [7:0]            sample_data,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  // Peripheral register map
  localparam int REG_CTRL = 0;
  localparam int REG_SEED = 4;
  localparam int REG_TAPS = 8;
  localparam int REG_DATA = 12;

  // Write slots: 0 ctrl=0, 1 seed, 2 taps, 3 ctrl=load, 4 ctrl=enable, 5 ctrl=0 (final)
  localparam logic [2:0] WR_LAST_CFG = 3'd4;
  localparam logic [2:0] WR_FINAL    = 3'd5;

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, SAMPLE, DONE
  } state_t;

  state_t                  state, state_n;
  logic [2:0]              wr_idx, wr_idx_n;
  logic [7:0]              seed_q, taps_q, rd_cnt;
  logic                    err_q;
  logic                    aw_ok, w_ok;
  logic                    aw_hs, w_hs;
  logic                    latch_cfg, load_wr, load_rd, cap_rd, set_err;
  logic [ADDR_WIDTH-1:0]   awaddr_q, araddr_q, wr_addr_n;
  logic [DATA_WIDTH-1:0]   wdata_q, wr_data_n;
  logic [7:0]              sample_q;

  // Valids/readies come only from registered state, never from an incoming ready
  assign m_axi_awvalid = (state == WR_REQ) && !aw_ok;
  assign m_axi_wvalid  = (state == WR_REQ) && !w_ok;
  assign m_axi_bready  = (state == WR_RESP);
  assign m_axi_arvalid = (state == RD_REQ);
  assign m_axi_rready  = (state == RD_RESP);
  assign sample_valid  = (state == SAMPLE);
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign error         = (state == DONE) && err_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_araddr  = araddr_q;
  assign sample_data   = sample_q;

  assign aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_hs  = m_axi_wvalid && m_axi_wready;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  // Next-state decode plus the load strobes for the datapath
  always_comb begin
    state_n   = state;
    wr_idx_n  = wr_idx;
    latch_cfg = 1'b0;
    load_wr   = 1'b0;
    load_rd   = 1'b0;
    cap_rd    = 1'b0;
    set_err   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          latch_cfg = 1'b1;
          wr_idx_n  = 3'd0;
          load_wr   = 1'b1;
          state_n   = WR_REQ;
        end
      end
      WR_REQ: begin
        // Each channel may finish on its own cycle or both together
        if ((aw_ok || aw_hs) && (w_ok || w_hs)) state_n = WR_RESP;
      end
      WR_RESP: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00) begin
            set_err = 1'b1;
            state_n = DONE;
          end else if (wr_idx == WR_FINAL) begin
            state_n = DONE;
          end else if (wr_idx == WR_LAST_CFG) begin
            if (rd_cnt == 8'd0) begin
              wr_idx_n = WR_FINAL;
              load_wr  = 1'b1;
              state_n  = WR_REQ;
            end else begin
              load_rd = 1'b1;
              state_n = RD_REQ;
            end
          end else begin
            wr_idx_n = wr_idx + 3'd1;
            load_wr  = 1'b1;
            state_n  = WR_REQ;
          end
        end
      end
      RD_REQ: begin
        if (m_axi_arready) state_n = RD_RESP;
      end
      RD_RESP: begin
        if (m_axi_rvalid) begin
          cap_rd  = 1'b1;
          state_n = SAMPLE;
        end
      end
      SAMPLE: begin
        if (sample_ready) begin
          if (rd_cnt != 8'd0) begin
            load_rd = 1'b1;
            state_n = RD_REQ;
          end else begin
            wr_idx_n = WR_FINAL;
            load_wr  = 1'b1;
            state_n  = WR_REQ;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Address/data for the write slot about to be issued
  always_comb begin
    wr_addr_n = ADDR_WIDTH'(REG_CTRL);
    wr_data_n = '0;
    case (wr_idx_n)
      3'd1: begin wr_addr_n = ADDR_WIDTH'(REG_SEED); wr_data_n = DATA_WIDTH'(seed_q); end
      3'd2: begin wr_addr_n = ADDR_WIDTH'(REG_TAPS); wr_data_n = DATA_WIDTH'(taps_q); end
      3'd3: wr_data_n = DATA_WIDTH'(2);
      3'd4: wr_data_n = DATA_WIDTH'(1);
      default: ;
    endcase
  end

  // Datapath: config latch, write slot, read countdown, captured sample, handshake tracking
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_idx   <= '0;
      seed_q   <= '0;
      taps_q   <= '0;
      rd_cnt   <= '0;
      err_q    <= 1'b0;
      aw_ok    <= 1'b0;
      w_ok     <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      araddr_q <= '0;
      sample_q <= '0;
    end else begin
      wr_idx <= wr_idx_n;
      if (latch_cfg) begin
        seed_q <= cfg_seed;
        taps_q <= cfg_taps;
        rd_cnt <= cfg_count;
        err_q  <= 1'b0;
      end
      if (set_err) err_q <= 1'b1;
      if (load_wr) begin
        awaddr_q <= wr_addr_n;
        wdata_q  <= wr_data_n;
      end
      if (load_rd) araddr_q <= ADDR_WIDTH'(REG_DATA);
      if (cap_rd) begin
        sample_q <= 8'(m_axi_rdata);
        if (rd_cnt != 8'd0) rd_cnt <= rd_cnt - 8'd1;
      end
      // Sticky per-channel completion, cleared whenever WR_REQ is left
      if (state == WR_REQ && state_n == WR_REQ) begin
        aw_ok <= aw_ok | aw_hs;
        w_ok  <= w_ok | w_hs;
      end else begin
        aw_ok <= 1'b0;
        w_ok  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_axi_master.sv
// Bench for lfsr_axi_master: AXI-Lite responder, sample consumer and sequence model.
module tb_lfsr_axi_master;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [7:0] cfg_seed = '0, cfg_taps = '0, cfg_count = '0;
  logic       busy, done, error, sample_valid;
  logic [7:0] sample_data;
  logic       sample_ready = 1'b0;
  logic [3:0] awaddr, araddr;
  logic       awvalid, awready = 1'b0;
  logic [7:0] wdata;
  logic       wvalid, wready = 1'b0;
  logic [1:0] bresp = '0;
  logic       bvalid = 1'b0, bready;
  logic       arvalid, arready = 1'b0;
  logic [7:0] rdata = '0;
  logic       rvalid = 1'b0, rready;

  always #5 clk = ~clk;

  lfsr_axi_master dut (
    .clk(clk), .resetn(resetn), .start(start),
    .cfg_seed(cfg_seed), .cfg_taps(cfg_taps), .cfg_count(cfg_count),
    .busy(busy), .done(done), .error(error),
    .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  typedef struct {
    logic [7:0] seed, taps, count;
    int         awd, wd, srd, err_wr;
    logic [1:0] resp;
    bit         busy_start;
    int         exp_writes, exp_reads, exp_err;
  } vec_t;

  // Responder configuration and observation logs
  int         aw_dly, w_dly, sr_dly, err_wr;
  logic [1:0] err_resp;
  logic [7:0] rd_src[256];
  logic [3:0] wl_a[$];
  logic [7:0] wl_d[$];
  logic [7:0] smp_log[$];
  int nreads, done_cnt, err_at_done, err_outside, aw_only, w_only;
  int hold_viol, stall_cyc, busy_viol, rd_i, bad_araddr;
  int checks = 0, passed = 0;

  // Responder private state
  int         aw_c, w_c, sr_c;
  bit         aw_got, w_got, b_pend, r_pend;
  logic [3:0] a_cap;
  logic [7:0] d_cap, last_s;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // AXI-Lite slave + sample sink: decisions made at negedge, handshakes land on next posedge
  initial begin
    forever begin
      @(negedge clk);
      if (!resetn) begin
        aw_c = 0; w_c = 0; sr_c = 0; aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0;
        sample_ready = 0;
        continue;
      end
      bvalid = 0; bresp = 0;
      if (b_pend) begin
        bvalid = 1;
        bresp = (wl_a.size() - 1 == err_wr) ? err_resp : 2'b00;
        if (bready) b_pend = 0;
      end
      rvalid = 0; rdata = 0;
      if (r_pend) begin
        rvalid = 1;
        rdata = rd_src[rd_i];
        if (rready) begin r_pend = 0; rd_i++; end
      end
      awready = 0; wready = 0;
      if (awvalid && !wvalid) aw_only++;
      if (!awvalid && wvalid) w_only++;
      if (awvalid) begin
        if (aw_c >= aw_dly) begin awready = 1; aw_got = 1; a_cap = awaddr; aw_c = 0; end
        else aw_c++;
      end
      if (wvalid) begin
        if (w_c >= w_dly) begin wready = 1; w_got = 1; d_cap = wdata; w_c = 0; end
        else w_c++;
      end
      if (aw_got && w_got) begin
        wl_a.push_back(a_cap); wl_d.push_back(d_cap);
        aw_got = 0; w_got = 0; b_pend = 1;
      end
      arready = 0;
      if (arvalid) begin
        arready = 1; nreads++; r_pend = 1;
        if (araddr != 4'hC) bad_araddr++;
      end
      sample_ready = 0;
      if (sample_valid) begin
        if (sr_c >= sr_dly) begin
          sample_ready = 1; smp_log.push_back(sample_data); sr_c = 0;
        end else begin
          if (sr_c > 0 && sample_data != last_s) hold_viol++;
          if (arvalid) hold_viol++;
          last_s = sample_data; stall_cyc++; sr_c++;
        end
      end
      if (done) begin
        done_cnt++; err_at_done = int'(error);
        if (!busy) busy_viol++;
      end else if (error) err_outside++;
      if (!busy && (awvalid || wvalid || arvalid || sample_valid || bready || rready))
        busy_viol++;
    end
  end

  task automatic clear_logs();
    wl_a.delete(); wl_d.delete(); smp_log.delete();
    nreads = 0; done_cnt = 0; err_at_done = -1; err_outside = 0; aw_only = 0; w_only = 0;
    hold_viol = 0; stall_cyc = 0; busy_viol = 0; rd_i = 0; bad_araddr = 0;
  endtask

  // One full sequence, checked against a list-level model of the expected traffic
  task automatic run(input vec_t v, input string tag, input bit use_tbl_exp);
    logic [3:0] ea[$];
    logic [7:0] ed[$];
    int n_wr, n_rd, ok, t, exp_err;
    clear_logs();
    aw_dly = v.awd; w_dly = v.wd; sr_dly = v.srd; err_wr = v.err_wr; err_resp = v.resp;
    @(posedge clk); #1;
    cfg_seed = v.seed; cfg_taps = v.taps; cfg_count = v.count; start = 1;
    @(posedge clk); #1;
    start = 0; cfg_seed = ~v.seed; cfg_taps = ~v.taps; cfg_count = v.count + 8'd1;
    if (v.busy_start) begin
      repeat (3) @(posedge clk);
      #1 start = 1;
      @(posedge clk); #1 start = 0;
    end
    t = 0;
    while (done_cnt == 0 && t < 5000) begin @(posedge clk); t++; end
    repeat (6) @(posedge clk);
    #1;
    // Model: the five config writes, the reads, the final disable; abort cuts after the bad write
    ea = '{4'h0, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0};
    ed = '{8'h00, v.seed, v.taps, 8'h02, 8'h01, 8'h00};
    n_wr = (v.err_wr >= 0) ? v.err_wr + 1 : 6;
    n_rd = (v.err_wr >= 0 && v.err_wr < 5) ? 0 : int'(v.count);
    exp_err = (v.err_wr >= 0) ? 1 : 0;
    if (use_tbl_exp) begin
      chk({tag, " tbl_writes"}, wl_a.size(), v.exp_writes);
      chk({tag, " tbl_reads"}, nreads, v.exp_reads);
      chk({tag, " tbl_error"}, err_at_done, v.exp_err);
    end
    chk({tag, " done_pulses"}, done_cnt, 1);
    chk({tag, " write_count"}, wl_a.size(), n_wr);
    ok = (wl_a.size() == n_wr) ? 1 : 0;
    if (ok == 1) for (int i = 0; i < n_wr; i++)
      if (wl_a[i] != ea[i] || wl_d[i] != ed[i]) ok = 0;
    chk({tag, " write_order"}, ok, 1);
    chk({tag, " read_count"}, nreads, n_rd);
    chk({tag, " araddr"}, bad_araddr, 0);
    ok = (smp_log.size() == n_rd) ? 1 : 0;
    if (ok == 1) for (int i = 0; i < n_rd; i++)
      if (smp_log[i] != rd_src[i]) ok = 0;
    chk({tag, " samples"}, ok, 1);
    chk({tag, " error_at_done"}, err_at_done, exp_err);
    chk({tag, " error_without_done"}, err_outside, 0);
    chk({tag, " sample_hold"}, hold_viol, 0);
    chk({tag, " stall_cycles"}, stall_cyc, v.srd * n_rd);
    chk({tag, " aw_only_cycles"}, aw_only, (v.awd > v.wd) ? (v.awd - v.wd) * n_wr : 0);
    chk({tag, " w_only_cycles"}, w_only, (v.wd > v.awd) ? (v.wd - v.awd) * n_wr : 0);
    chk({tag, " busy_consistency"}, busy_viol, 0);
    chk({tag, " idle_after"}, int'(busy), 0);
  endtask

  vec_t tbl[7];
  vec_t rv;
  logic [7:0] pat[3];
  int wl_at_rst;

  initial begin
    //          seed   taps   cnt    awd wd srd err resp   bs  wr  rd err
    tbl[0] = '{8'hA5, 8'hB4, 8'd3,   0, 0, 0, -1, 2'b00, 0,  6,  3, 0};
    tbl[1] = '{8'h12, 8'h34, 8'd2,   2, 4, 0, -1, 2'b00, 0,  6,  2, 0};
    tbl[2] = '{8'h5A, 8'hC3, 8'd2,   0, 0, 5, -1, 2'b00, 0,  6,  2, 0};
    tbl[3] = '{8'hA5, 8'hB4, 8'd3,   0, 0, 0,  2, 2'b10, 0,  3,  0, 1};
    tbl[4] = '{8'h77, 8'h88, 8'd0,   0, 0, 0, -1, 2'b00, 1,  6,  0, 0};
    tbl[5] = '{8'h3C, 8'h5D, 8'd1,   1, 0, 1,  5, 2'b11, 0,  6,  1, 1};
    tbl[6] = '{8'hFF, 8'h01, 8'd255, 0, 0, 0, -1, 2'b00, 0,  6, 255, 0};
    pat[0] = 8'h4B; pat[1] = 8'h97; pat[2] = 8'h2E;
    clear_logs();
    aw_dly = 0; w_dly = 0; sr_dly = 0; err_wr = -1; err_resp = 2'b00;

    // Reset held three cycles: every output quiet
    resetn = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_flags", int'({busy, done, error, sample_valid}), 0);
    chk("reset_handshakes", int'({awvalid, wvalid, bready, arvalid, rready}), 0);
    chk("reset_buses", int'({awaddr, araddr, wdata, sample_data}), 0);
    resetn = 1;

    for (int i = 0; i < 256; i++) rd_src[i] = pat[i % 3];
    for (int k = 0; k < 7; k++) run(tbl[k], $sformatf("vec%0d", k), 1'b1);

    for (int k = 0; k < 10; k++) begin
      rv.seed = 8'($urandom); rv.taps = 8'($urandom);
      rv.count = 8'($urandom_range(0, 12));
      rv.awd = $urandom_range(0, 3); rv.wd = $urandom_range(0, 3);
      rv.srd = $urandom_range(0, 3);
      rv.err_wr = ($urandom_range(0, 1) == 1) ? -1 : int'($urandom_range(0, 5));
      rv.resp = 2'($urandom_range(2, 3));
      rv.busy_start = 1'($urandom_range(0, 1));
      rv.exp_writes = 0; rv.exp_reads = 0; rv.exp_err = 0;
      for (int i = 0; i < 256; i++) rd_src[i] = 8'($urandom);
      run(rv, $sformatf("rnd%0d", k), 1'b0);
    end

    // Reset in the middle of the write phase: abandoned, no done, no further traffic
    clear_logs();
    aw_dly = 1; w_dly = 2; sr_dly = 0; err_wr = -1;
    @(posedge clk); #1;
    cfg_seed = 8'h11; cfg_taps = 8'h22; cfg_count = 8'd4; start = 1;
    @(posedge clk); #1 start = 0;
    repeat (5) @(posedge clk);
    #1 resetn = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_flags", int'({busy, done, error, sample_valid}), 0);
    chk("midrst_handshakes", int'({awvalid, wvalid, bready, arvalid, rready}), 0);
    chk("midrst_buses", int'({awaddr, araddr, wdata, sample_data}), 0);
    wl_at_rst = wl_a.size();
    resetn = 1;
    repeat (40) @(posedge clk);
    #1;
    chk("midrst_no_done", done_cnt, 0);
    chk("midrst_no_traffic", wl_a.size() + nreads, wl_at_rst);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
